test_finisher: RTL

Memory-mapped end-of-test device for the rvseed core. Programs store a result word to a TOHOST register, and the block raises done and pass/fail flags with the failing test number. This replaces hierarchical register-file probing with a bus-visible completion mechanism. It also exposes a free-running cycle counter and an optional watchdog timeout, and it sits as a responder on the core's data-memory port.

---
 rtl/rvseed_defines.sv | 31 +++
 rtl/tf_cycle_counter.sv | 47 ++++
 rtl/test_finisher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rvseed_defines.sv
// Shared constants for the rvseed core and its simulation-side devices.
package rvseed_defines;

  localparam int CPU_WIDTH = 32;

  localparam logic [3:0] TF_TOHOST   = 4'h0;
  localparam logic [3:0] TF_CYCLE_LO = 4'h4;
  localparam logic [3:0] TF_CYCLE_HI = 4'h8;
  localparam logic [3:0] TF_STATUS   = 4'hC;

  localparam int TF_ST_DONE    = 0;
  localparam int TF_ST_PASS    = 1;
  localparam int TF_ST_TIMEOUT = 2;

  typedef enum logic {
    TF_RUN  = 1'b0,
    TF_DONE = 1'b1
  } tf_state_e;

  function automatic logic [CPU_WIDTH-1:0] tf_status_word(input logic done,
                                                           input logic pass,
                                                           input logic timeout);
    logic [CPU_WIDTH-1:0] w;
    w = '0;
    w[TF_ST_DONE]    = done;
    w[TF_ST_PASS]    = pass;
    w[TF_ST_TIMEOUT] = timeout;
    return w;
  endfunction

endpackage

// File: rtl/tf_cycle_counter.sv
// 64-bit cycle counter with a LO-read-triggered HI shadow; the watchdog
// terminal-count compare exists only when TEST_FINISHER_TIMEOUT_EN is defined.
module tf_cycle_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lo_rd,
  output logic [31:0] cnt_lo,
  output logic [31:0] hi_shadow
`ifdef TEST_FINISHER_TIMEOUT_EN
  ,
  output logic        expired
`endif
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    cnt_d    = en ? cnt_q + 64'd1 : cnt_q;
    // HI is latched from the pre-edge count so a LO/HI pair is coherent
    shadow_d = lo_rd ? cnt_q[63:32] : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_lo    = cnt_q[31:0];
  assign hi_shadow = shadow_q;

`ifdef TEST_FINISHER_TIMEOUT_EN
  assign expired = en && (cnt_q == 64'(TIMEOUT_CYCLES));
`else
  logic unused_param;
  assign unused_param = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: rtl/test_finisher.sv
// Memory-mapped end-of-test device: TOHOST result, cycle counter, status.
// Optional watchdog compiled in with TEST_FINISHER_TIMEOUT_EN.
module test_finisher
  import rvseed_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic                 req_we,
  input  logic [3:0]           req_addr,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [CPU_WIDTH-1:0] rsp_rdata,
  output logic                 sim_done,
  output logic                 sim_pass,
  output logic                 sim_timeout,
  output logic [CPU_WIDTH-1:0] fail_testnum
);

  tf_state_e            state_q, state_d;
  logic                 pass_q, pass_d;
  logic [CPU_WIDTH-1:0] testnum_q, testnum_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [CPU_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CPU_WIDTH-1:0] rd_data;
  logic [31:0]          cnt_lo, hi_shadow;
  logic                 acc, rd_acc, wr_acc, running, term;

  assign req_rdy = !rsp_vld_q || rsp_rdy;
  assign acc     = req_vld && req_rdy;
  assign rd_acc  = acc && !req_we;
  assign wr_acc  = acc && req_we;
  assign running = (state_q == TF_RUN);
  assign term    = running && wr_acc && (req_addr == TF_TOHOST) && req_wdata[0];

`ifdef TEST_FINISHER_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_expired;
`endif

  tf_cycle_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (running),
    .lo_rd    (rd_acc && (req_addr == TF_CYCLE_LO)),
    .cnt_lo   (cnt_lo),
    .hi_shadow(hi_shadow)
`ifdef TEST_FINISHER_TIMEOUT_EN
    ,
    .expired  (wd_expired)
`endif
  );

  always_comb begin
    rd_data = '0;
    case (req_addr)
      TF_CYCLE_LO: rd_data = cnt_lo;
      TF_CYCLE_HI: rd_data = hi_shadow;
      TF_STATUS:   rd_data = tf_status_word(!running, pass_q, sim_timeout);
      default:     rd_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    testnum_d   = testnum_q;
`ifdef TEST_FINISHER_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    rsp_vld_d   = rd_acc ? 1'b1 : (rsp_rdy ? 1'b0 : rsp_vld_q);
    rsp_rdata_d = rd_acc ? rd_data : rsp_rdata_q;
    // a terminating write beats a same-cycle watchdog expiry
    if (term) begin
      state_d   = TF_DONE;
      pass_d    = (req_wdata == CPU_WIDTH'(1));
      testnum_d = req_wdata >> 1;
    end
`ifdef TEST_FINISHER_TIMEOUT_EN
    else if (wd_expired) begin
      state_d   = TF_DONE;
      pass_d    = 1'b0;
      testnum_d = '0;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TF_RUN;
      pass_q      <= 1'b0;
      testnum_q   <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef TEST_FINISHER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      testnum_q   <= testnum_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef TEST_FINISHER_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

`ifdef TEST_FINISHER_TIMEOUT_EN
  assign sim_timeout = timeout_q;
`else
  assign sim_timeout = 1'b0;
`endif

  assign rsp_vld      = rsp_vld_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign sim_done     = !running;
  assign sim_pass     = pass_q;
  assign fail_testnum = testnum_q;

endmodule
